sd_spi_responder: RTL and testbench
===================================

# sd_spi_responder

SPI-mode SD card responder: the card-side end of the SD/SPI link our autotest harness drives as master. It decodes command frames on `mosi`, answers on `miso`, and serves single-block reads and writes from an external byte-wide memory port. It stands in for a physical card in simulation and in hardware-in-loop builds, so autotest vector and result transfers can run without an SD card.

## Interface
- `BLOCK_W`, 16: block-address bits taken from the command argument LSBs.
- `NCR_BYTES`, 1: 0xFF bytes sent between the end of a command and its R1 response (1..8).
- `READ_GAP_BYTES`, 2: 0xFF bytes between R1 and the 0xFE data token on CMD17.
- `BUSY_BYTES`, 4: 0x00 busy bytes after the data response on CMD24.
- `clk` in 1: system clock; must be at least 8× the `sclk` frequency.
- `rst` in 1: asynchronous, active-high reset.
- `cs` in 1: chip select from master, active low; asynchronous to `clk`.
- `sclk` in 1: SPI clock, mode 0; asynchronous to `clk`.
- `mosi` in 1: serial data from master.
- `miso` out 1: serial data to master.
- `mem_addr` out BLOCK_W+9: {block, byte index 0..511}.
- `mem_re` out 1: read strobe; `mem_rdata` is valid the following cycle.
- `mem_rdata` in 8: memory read data.
- `mem_we` out 1: write strobe, one cycle per byte.
- `mem_wdata` out 8: write data.
- `idle_o` out 1: card is in the idle state (R1 bit 0).

## Operation
- `cs`, `sclk` and `mosi` each pass through a 2-flop synchronizer. Edges are detected on the synchronized `sclk`.
- On a rising edge with `cs` low, `mosi` is shifted in MSB first.
- On a falling edge, `miso` shifts out the next bit. The first bit of every byte is presented on the falling edge that ends the previous byte.
- `cs` high:
  - Forces state CMD_WAIT, clears bit and byte counters, and drives `miso`=1.
  - Drops any in-progress transaction. Bytes already written to memory stay written.
- **CMD_WAIT:** ignores input bytes until one matches 01xxxxxx, then collects 6 bytes (cmd, arg[31:0], crc). CRC is not checked.
- **NCR:** sends NCR_BYTES × 0xFF, then R1.
- **R1 values:**
  - Bit 0 is `idle_o`.
  - CMD0: 0x01 and sets `idle_o`.
  - CMD8: 0x01 followed by arg[31:0] echoed.
  - CMD55: R1, and arms the app flag for the next command only.
  - ACMD41 (CMD41 with app flag armed): 0x00 and clears `idle_o`.
  - CMD16: R1 with no further action.
  - CMD17/CMD24 while `idle_o`=1, unknown commands, and CMD41 without the app flag: 0x04|idle.
- **CMD17, READ path:** R1 0x00, then READ_GAP_BYTES × 0xFF, token 0xFE, 512 bytes at block = arg[BLOCK_W-1:0], bytes 0..511 in order, then 2 × 0xFF CRC. Returns to CMD_WAIT.
  - Each byte is prefetched: `mem_re` pulses one cycle with `mem_addr` at the start of the previous byte's shift.
- **CMD24, WRITE path:** R1 0x00, then wait for an input byte 0xFE. Bytes other than 0xFE are ignored.
  - Receive 512 bytes. Each completed byte pulses `mem_we` with `mem_addr`/`mem_wdata` one cycle after its 8th rising edge.
  - Discard 2 CRC bytes, send data response 0x05, then BUSY_BYTES × 0x00, then return to CMD_WAIT. `miso`=1 on idle bytes.
- Bytes received while a response is being sent are ignored, except for the WRITE token and data bytes.
- **Reset values:** `miso`=1, `mem_re`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `idle_o`=1, state CMD_WAIT, app flag cleared.

## Timing
- Input-to-edge-detect latency is 3 `clk` cycles.
- `miso` changes at most 4 `clk` cycles after the falling `sclk` pad edge. This is valid for the master's next rising edge given `clk` ≥ 8× `sclk`.
- `mem_rdata` is captured exactly 1 cycle after `mem_re`. Reads and writes never occur in the same cycle.
- Byte counter wraps are not allowed. Byte 511 is followed by the CRC phase, and `mem_addr` never advances past index 511.
- `cs` rising at any state takes effect within 3 cycles. A `mem_we` that has already been issued completes; no further memory strobes follow.

## Test plan
- **Reset state:** assert `rst` mid-READ → `miso`=1, `idle_o`=1, no strobes, next CMD0 answered with 0x01.
- **Init sequence:** CMD0, CMD8 (arg 0x000001AA), CMD55, ACMD41 → responses 0x01, 0x01+00 00 01 AA, 0x01, 0x00; `idle_o` falls after ACMD41.
- **Block read:** memory block 3 holds byte i = i[7:0]; CMD17 arg 3 → 0x00, 2×0xFF, 0xFE, 00..FF, 00..FF, FF FF. Exactly 512 `mem_re` pulses, addresses 3·512..3·512+511.
- **Block write:** CMD24 arg 5, token 0xFE, 512 bytes of 0xA5^i, CRC → 512 `mem_we` pulses with correct address/data, then 0x05, 4×0x00, 0xFF.
- **Illegal commands:** CMD17 before ACMD41 → 0x05 with no memory access. CMD41 without CMD55 → 0x05.
- **Abort:** `cs` raised after 100 write bytes → 100 writes only, `miso`=1; the following CMD17 behaves normally.

Source files
------------

// File: rtl/sd_spi_responder_if.sv
// SD/SPI link and byte-wide memory port between the harness and the responder.
interface sd_spi_responder_if #(
  parameter int unsigned BLOCK_W = 16
);
  logic               cs;
  logic               sclk;
  logic               mosi;
  logic               miso;
  logic [BLOCK_W+8:0] mem_addr;
  logic               mem_re;
  logic [7:0]         mem_rdata;
  logic               mem_we;
  logic [7:0]         mem_wdata;
  logic               idle_o;

  modport slave (
    input  cs, sclk, mosi, mem_rdata,
    output miso, mem_addr, mem_re, mem_we, mem_wdata, idle_o
  );

  modport master (
    output cs, sclk, mosi, mem_rdata,
    input  miso, mem_addr, mem_re, mem_we, mem_wdata, idle_o
  );
endinterface

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card stand-in: command decode, R1/echo responses, and
// single-block reads/writes served from an external byte-wide memory.
module sd_spi_responder #(
  parameter int unsigned BLOCK_W        = 16,
  parameter int unsigned NCR_BYTES      = 1,
  parameter int unsigned READ_GAP_BYTES = 2,
  parameter int unsigned BUSY_BYTES     = 4
) (
  input  logic              clk,
  input  logic              rst,
  sd_spi_responder_if.slave bus
);
  localparam logic [7:0] NCR_N  = 8'(NCR_BYTES);
  localparam logic [7:0] GAP_N  = 8'(READ_GAP_BYTES);
  localparam logic [7:0] BUSY_N = 8'(BUSY_BYTES);

  typedef enum logic [3:0] {
    CMD_WAIT, CMD_COLLECT, NCR, R1, ECHO,
    RD_GAP, RD_TOKEN, RD_DATA, RD_CRC,
    WR_TOKEN, WR_DATA, WR_CRC, WR_RESP, WR_BUSY
  } state_t;

  logic [2:0] sclk_sy;
  logic [1:0] cs_sy, mosi_sy;

  state_t             state;
  logic [2:0]         bit_cnt;
  logic [6:0]         rx_sr;
  logic [7:0]         tx_sr, tx_next;
  logic [7:0]         cnt;
  logic [8:0]         idx;
  logic [5:0]         cmd_r;
  logic [31:0]        arg_r;
  logic               app_r, idle_r;
  logic [7:0]         r1_r, rd_buf;
  logic               re_d;
  logic               miso_r, mem_re_r, mem_we_r;
  logic [BLOCK_W+8:0] mem_addr_r;
  logic [7:0]         mem_wdata_r;

  logic               sclk_rise, sclk_fall, cs_n_s, mosi_s, byte_done;
  logic [7:0]         rx_byte, r1_dec;
  logic               idle_dec;
  logic [BLOCK_W-1:0] blk;

  assign sclk_rise = sclk_sy[1] & ~sclk_sy[2];
  assign sclk_fall = ~sclk_sy[1] & sclk_sy[2];
  assign cs_n_s    = cs_sy[1];
  assign mosi_s    = mosi_sy[1];
  assign rx_byte   = {rx_sr, mosi_s};
  assign byte_done = sclk_rise & ~cs_n_s & (bit_cnt == 3'd7);
  assign blk       = arg_r[BLOCK_W-1:0];

  assign bus.miso      = miso_r;
  assign bus.mem_re    = mem_re_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.idle_o    = idle_r;

  // Two-flop synchronizers; sclk gets a third flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sy <= '0;
      cs_sy   <= '1;
      mosi_sy <= '1;
    end else begin
      sclk_sy <= {sclk_sy[1:0], bus.sclk};
      cs_sy   <= {cs_sy[0], bus.cs};
      mosi_sy <= {mosi_sy[0], bus.mosi};
    end
  end

  // R1 value and idle update for the command just collected.
  always_comb begin
    r1_dec   = {5'b0, 1'b1, 1'b0, idle_r};
    idle_dec = idle_r;
    case (cmd_r)
      6'd0:               begin r1_dec = 8'h01; idle_dec = 1'b1; end
      6'd8, 6'd16, 6'd55: r1_dec = {7'b0, idle_r};
      6'd41:              if (app_r) begin r1_dec = 8'h00; idle_dec = 1'b0; end
      6'd17, 6'd24:       if (!idle_r) r1_dec = 8'h00;
      default: ;
    endcase
  end

  // Bit shifting plus byte-level protocol FSM; tx_next is chosen at each
  // byte boundary and presented on the falling edge that follows it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= CMD_WAIT;
      bit_cnt     <= '0;
      rx_sr       <= '0;
      tx_sr       <= '1;
      tx_next     <= '1;
      cnt         <= '0;
      idx         <= '0;
      cmd_r       <= '0;
      arg_r       <= '0;
      app_r       <= 1'b0;
      idle_r      <= 1'b1;
      r1_r        <= '0;
      rd_buf      <= '0;
      re_d        <= 1'b0;
      miso_r      <= 1'b1;
      mem_re_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else begin
      mem_re_r <= 1'b0;
      mem_we_r <= 1'b0;
      re_d     <= mem_re_r;
      if (re_d) rd_buf <= bus.mem_rdata;

      if (cs_n_s) begin
        state   <= CMD_WAIT;
        bit_cnt <= '0;
        cnt     <= '0;
        miso_r  <= 1'b1;
        tx_sr   <= '1;
        tx_next <= '1;
      end else begin
        if (sclk_fall) begin
          if (bit_cnt == 3'd0) begin
            miso_r <= tx_next[7];
            tx_sr  <= {tx_next[6:0], 1'b1};
          end else begin
            miso_r <= tx_sr[7];
            tx_sr  <= {tx_sr[6:0], 1'b1};
          end
        end
        if (sclk_rise) begin
          rx_sr   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (byte_done) begin
          tx_next <= 8'hFF;
          case (state)
            CMD_WAIT: if (rx_byte[7:6] == 2'b01) begin
              cmd_r <= rx_byte[5:0];
              cnt   <= 8'd1;
              state <= CMD_COLLECT;
            end
            CMD_COLLECT: if (cnt < 8'd5) begin
              arg_r <= {arg_r[23:0], rx_byte};
              cnt   <= cnt + 8'd1;
            end else begin
              r1_r   <= r1_dec;
              idle_r <= idle_dec;
              app_r  <= (cmd_r == 6'd55);
              cnt    <= 8'd1;
              state  <= NCR;
            end
            NCR: if (cnt == NCR_N) begin
              tx_next <= r1_r;
              state   <= R1;
            end else cnt <= cnt + 8'd1;
            R1: begin
              cnt <= 8'd1;
              if (cmd_r == 6'd8) begin
                tx_next <= arg_r[31:24];
                arg_r   <= {arg_r[23:0], 8'h00};
                state   <= ECHO;
              end else if (cmd_r == 6'd17 && r1_r == 8'h00) state <= RD_GAP;
              else if (cmd_r == 6'd24 && r1_r == 8'h00)     state <= WR_TOKEN;
              else                                           state <= CMD_WAIT;
            end
            ECHO: if (cnt == 8'd4) state <= CMD_WAIT;
            else begin
              tx_next <= arg_r[31:24];
              arg_r   <= {arg_r[23:0], 8'h00};
              cnt     <= cnt + 8'd1;
            end
            RD_GAP: if (cnt == GAP_N) begin
              tx_next    <= 8'hFE;
              mem_re_r   <= 1'b1;
              mem_addr_r <= {blk, 9'd0};
              state      <= RD_TOKEN;
            end else cnt <= cnt + 8'd1;
            RD_TOKEN: begin
              tx_next    <= rd_buf;
              idx        <= '0;
              mem_re_r   <= 1'b1;
              mem_addr_r <= {blk, 9'd1};
              state      <= RD_DATA;
            end
            // idx is the byte that just left; fetch runs one byte ahead
            // and stops at 511 so the address never wraps.
            RD_DATA: if (idx == 9'd511) begin
              cnt   <= 8'd1;
              state <= RD_CRC;
            end else begin
              tx_next <= rd_buf;
              idx     <= idx + 9'd1;
              if (idx != 9'd510) begin
                mem_re_r   <= 1'b1;
                mem_addr_r <= {blk, idx + 9'd2};
              end
            end
            RD_CRC: if (cnt == 8'd2) state <= CMD_WAIT;
            else cnt <= cnt + 8'd1;
            WR_TOKEN: if (rx_byte == 8'hFE) begin
              idx   <= '0;
              state <= WR_DATA;
            end
            WR_DATA: begin
              mem_we_r    <= 1'b1;
              mem_addr_r  <= {blk, idx};
              mem_wdata_r <= rx_byte;
              if (idx == 9'd511) begin
                cnt   <= 8'd1;
                state <= WR_CRC;
              end else idx <= idx + 9'd1;
            end
            WR_CRC: if (cnt == 8'd2) begin
              tx_next <= 8'h05;
              state   <= WR_RESP;
            end else cnt <= cnt + 8'd1;
            WR_RESP: begin
              tx_next <= 8'h00;
              cnt     <= 8'd1;
              state   <= WR_BUSY;
            end
            WR_BUSY: if (cnt == BUSY_N) state <= CMD_WAIT;
            else begin
              tx_next <= 8'h00;
              cnt     <= cnt + 8'd1;
            end
            default: state <= CMD_WAIT;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_sd_spi_responder.sv
// Bench for sd_spi_responder: SPI master tasks, a response scoreboard and
// memory-port scoreboards fed when stimulus is driven.
module tb_sd_spi_responder;
  localparam int unsigned BW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sd_spi_responder_if #(.BLOCK_W(BW)) bus ();

  sd_spi_responder #(
    .BLOCK_W(BW), .NCR_BYTES(1), .READ_GAP_BYTES(2), .BUSY_BYTES(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int re_cnt   = 0;
  int we_cnt   = 0;

  logic [7:0]     resp_q[$];
  logic [BW+8:0]  rd_q[$];
  logic [BW+16:0] wr_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model: a read returns the low address byte one cycle later.
  always @(posedge clk) begin
    if (rst) bus.mem_rdata <= 8'h00;
    else if (bus.mem_re) bus.mem_rdata <= bus.mem_addr[7:0];
  end

  // Memory-port scoreboards, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_re && bus.mem_we) check("re_we_overlap", 32'd1, 32'd0);
      if (bus.mem_re) begin
        re_cnt++;
        if (rd_q.size() == 0) check("re_unexpected", 32'(bus.mem_addr), 32'hFFFFFFFF);
        else check("re_addr", 32'(bus.mem_addr), 32'(rd_q.pop_front()));
      end
      if (bus.mem_we) begin
        we_cnt++;
        if (wr_q.size() == 0) check("we_unexpected", 32'(bus.mem_addr), 32'hFFFFFFFF);
        else check("we_addr_data", 32'({bus.mem_addr, bus.mem_wdata}), 32'(wr_q.pop_front()));
      end
    end
  end

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      bus.mosi = tx[i];
      repeat (4) @(posedge clk);
      #1;
      rx[i]    = bus.miso;
      bus.sclk = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      bus.sclk = 1'b0;
    end
  endtask

  task automatic xchk(input string tag, input logic [7:0] tx);
    logic [7:0] rx;
    xfer(tx, rx);
    if (resp_q.size() == 0) check({tag, "_noexp"}, 32'(rx), 32'hFFFFFFFF);
    else check(tag, 32'(rx), 32'(resp_q.pop_front()));
  endtask

  task automatic drain(input string tag);
    while (resp_q.size() > 0) xchk(tag, 8'hFF);
  endtask

  task automatic send_cmd(input logic [5:0] c, input logic [31:0] arg);
    logic [7:0] rx;
    xfer({2'b01, c}, rx);
    for (int i = 3; i >= 0; i--) xfer(arg[i*8 +: 8], rx);
    xfer(8'h95, rx);
  endtask

  task automatic cs_set(input logic v);
    @(posedge clk);
    #1;
    bus.cs = v;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic push_r1(input logic [7:0] r1);
    resp_q.push_back(8'hFF);
    resp_q.push_back(r1);
  endtask

  initial begin
    int re0, we0;
    bus.cs = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_miso", 32'(bus.miso), 32'd1);
    check("rst_idle", 32'(bus.idle_o), 32'd1);
    check("rst_re", 32'(bus.mem_re), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    cs_set(1'b0);

    // Illegal commands before initialisation.
    re0 = re_cnt;
    send_cmd(6'd17, 32'd0); push_r1(8'h05); resp_q.push_back(8'hFF); drain("cmd17_idle");
    check("cmd17_idle_nore", 32'(re_cnt), 32'(re0));
    send_cmd(6'd41, 32'd0); push_r1(8'h05); drain("cmd41_noapp");

    // Init sequence.
    send_cmd(6'd0, 32'd0); push_r1(8'h01); drain("cmd0");
    send_cmd(6'd8, 32'h000001AA); push_r1(8'h01);
    resp_q.push_back(8'h00); resp_q.push_back(8'h00);
    resp_q.push_back(8'h01); resp_q.push_back(8'hAA); resp_q.push_back(8'hFF);
    drain("cmd8");
    send_cmd(6'd55, 32'd0); push_r1(8'h01); drain("cmd55");
    check("idle_before_acmd41", 32'(bus.idle_o), 32'd1);
    send_cmd(6'd41, 32'h40000000); push_r1(8'h00); drain("acmd41");
    check("idle_after_acmd41", 32'(bus.idle_o), 32'd0);

    // Block read of block 3.
    re0 = re_cnt;
    for (int i = 0; i < 512; i++) rd_q.push_back({16'd3, 9'(i)});
    send_cmd(6'd17, 32'd3); push_r1(8'h00);
    resp_q.push_back(8'hFF); resp_q.push_back(8'hFF); resp_q.push_back(8'hFE);
    for (int i = 0; i < 512; i++) resp_q.push_back(8'(i));
    resp_q.push_back(8'hFF); resp_q.push_back(8'hFF); resp_q.push_back(8'hFF);
    drain("rd_blk");
    check("rd_re_count", 32'(re_cnt - re0), 32'd512);
    check("rd_q_left", 32'(rd_q.size()), 32'd0);

    // Block write of block 5.
    we0 = we_cnt;
    send_cmd(6'd24, 32'd5); push_r1(8'h00); drain("wr_r1");
    resp_q.push_back(8'hFF); xchk("wr_token", 8'hFE);
    for (int i = 0; i < 512; i++) begin
      logic [7:0] d;
      d = 8'hA5 ^ 8'(i);
      wr_q.push_back({16'd5, 9'(i), d});
      resp_q.push_back(8'hFF);
      xchk("wr_data_miso", d);
    end
    resp_q.push_back(8'hFF); xchk("wr_crc0", 8'h12);
    resp_q.push_back(8'hFF); xchk("wr_crc1", 8'h34);
    resp_q.push_back(8'h05);
    for (int i = 0; i < 4; i++) resp_q.push_back(8'h00);
    resp_q.push_back(8'hFF);
    drain("wr_resp");
    check("wr_we_count", 32'(we_cnt - we0), 32'd512);

    // Abort a write after 100 bytes.
    we0 = we_cnt;
    send_cmd(6'd24, 32'd5); push_r1(8'h00); drain("ab_r1");
    resp_q.push_back(8'hFF); xchk("ab_token", 8'hFE);
    for (int i = 0; i < 100; i++) begin
      wr_q.push_back({16'd5, 9'(i), 8'(i) ^ 8'h3C});
      resp_q.push_back(8'hFF);
      xchk("ab_data_miso", 8'(i) ^ 8'h3C);
    end
    cs_set(1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("ab_miso", 32'(bus.miso), 32'd1);
    check("ab_we_count", 32'(we_cnt - we0), 32'd100);
    check("ab_wr_q_left", 32'(wr_q.size()), 32'd0);
    cs_set(1'b0);

    // Read after abort, then reset in the middle of it.
    for (int i = 0; i < 512; i++) rd_q.push_back({16'd3, 9'(i)});
    send_cmd(6'd17, 32'd3); push_r1(8'h00);
    resp_q.push_back(8'hFF); resp_q.push_back(8'hFF); resp_q.push_back(8'hFE);
    for (int i = 0; i < 8; i++) resp_q.push_back(8'(i));
    drain("rd2");
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rd_q.delete();
    check("mid_rst_miso", 32'(bus.miso), 32'd1);
    check("mid_rst_idle", 32'(bus.idle_o), 32'd1);
    check("mid_rst_re", 32'(bus.mem_re), 32'd0);
    check("mid_rst_we", 32'(bus.mem_we), 32'd0);
    re0 = re_cnt;
    we0 = we_cnt;
    rst = 1'b0;
    cs_set(1'b1);
    cs_set(1'b0);
    send_cmd(6'd0, 32'd0); push_r1(8'h01); drain("cmd0_after_rst");
    check("post_rst_no_re", 32'(re_cnt), 32'(re0));
    check("post_rst_no_we", 32'(we_cnt), 32'(we0));
    cs_set(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
